// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the multi-port integer register file.
package regfile_pkg;

  localparam int unsigned XLEN_DEFAULT  = 64;
  localparam int unsigned NREGS_DEFAULT = 32;
  localparam int unsigned AW_DEFAULT    = $clog2(NREGS_DEFAULT);

  typedef logic [AW_DEFAULT-1:0]   reg_addr_t;
  typedef logic [XLEN_DEFAULT-1:0] xdata_t;

  // CLEAR: post-reset sequencer zeroing the array; READY: normal operation
  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

endpackage : regfile_pkg

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
// Set by alloc, cleared by any enabled write, alloc wins on a same-cycle hit.
// Register 0 is never busy. Busy outputs reflect registered state only.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS = NREGS_DEFAULT,
  parameter int unsigned NRD   = 2,
  parameter int unsigned NWR   = 1,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ready_i,
  input  logic              alloc_en_i,
  input  logic [AW-1:0]     alloc_addr_i,
  input  logic [NWR-1:0]    wr_en_i,
  input  logic [NWR*AW-1:0] wr_addr_i,
  input  logic [NRD*AW-1:0] rd_addr_i,
  output logic [NRD-1:0]    busy_o
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Next busy vector: write clears first, alloc sets last so it wins
  always_comb begin
    busy_d = busy_q;
    if (ready_i) begin
      for (int p = 0; p < NWR; p++) begin
        if (wr_en_i[p]) begin
          busy_d[wr_addr_i[p*AW +: AW]] = 1'b0;
        end
      end
      if (alloc_en_i) begin
        busy_d[alloc_addr_i] = 1'b1;
      end
    end
    busy_d[0] = 1'b0;
  end

  // Busy vector register, cleared by reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Per-read-port lookup of the registered busy state
  always_comb begin
    busy_o = '0;
    for (int r = 0; r < NRD; r++) begin
      busy_o[r] = busy_q[rd_addr_i[r*AW +: AW]];
    end
  end

endmodule : regfile_scoreboard

// File: rtl/regfile_multiport.sv
// Parametrised multi-port register file: NRD combinational read ports,
// NWR synchronous write ports, hardwired-zero x0, same-cycle write bypass,
// and a post-reset sequencer that zeroes one entry per cycle before READY.
// Optional pending-write scoreboard enabled with REGFILE_SCOREBOARD_EN.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEFAULT,
  parameter int unsigned NREGS = NREGS_DEFAULT,
  parameter int unsigned NRD   = 2,
  parameter int unsigned NWR   = 1,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  output logic                ready_o,
  input  logic [NRD*AW-1:0]   rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  input  logic [NWR-1:0]      wr_en_i,
  input  logic [NWR*AW-1:0]   wr_addr_i,
  input  logic [NWR*XLEN-1:0] wr_data_i
`ifdef REGFILE_SCOREBOARD_EN
  ,
  input  logic                alloc_en_i,
  input  logic [AW-1:0]       alloc_addr_i,
  output logic [NRD-1:0]      busy_o
`endif
);

  localparam int unsigned LAST = NREGS - 1;

  rf_state_e         state_q;
  rf_state_e         state_d;
  logic [AW-1:0]     clr_cnt_q;
  logic [AW-1:0]     clr_cnt_d;
  logic              clr_we;
  logic              ready;

  logic [XLEN-1:0]   mem_q [NREGS];
  logic [AW-1:0]     wr_addr_w [NWR];
  logic [XLEN-1:0]   wr_data_w [NWR];

  assign ready   = (state_q == RF_READY);
  assign ready_o = ready;

  // Unpack flattened write-port buses
  always_comb begin
    for (int p = 0; p < NWR; p++) begin
      wr_addr_w[p] = wr_addr_i[p*AW +: AW];
      wr_data_w[p] = wr_data_i[p*XLEN +: XLEN];
    end
  end

  // State and clear-counter registers; reset restarts clearing at entry 1
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= RF_CLEAR;
      clr_cnt_q <= AW'(1);
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Clear sequencer next-state: step through entries 1..NREGS-1, then READY
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_we    = 1'b0;
    case (state_q)
      RF_CLEAR: begin
        clr_we    = 1'b1;
        clr_cnt_d = clr_cnt_q + AW'(1);
        if (clr_cnt_q == AW'(LAST)) begin
          state_d = RF_READY;
        end
      end
      RF_READY: begin
        state_d = RF_READY;
      end
      default: begin
        state_d = RF_CLEAR;
      end
    endcase
  end

  // Array update: sequencer zeroing in CLEAR, port writes in READY.
  // Later ports are assigned last, so the highest-indexed port wins.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (clr_we) begin
        mem_q[clr_cnt_q] <= '0;
      end else if (ready) begin
        for (int p = 0; p < NWR; p++) begin
          if (wr_en_i[p] && (wr_addr_w[p] != '0)) begin
            mem_q[wr_addr_w[p]] <= wr_data_w[p];
          end
        end
      end
    end
  end

  for (genvar r = 0; r < NRD; r++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;

    assign addr = rd_addr_i[r*AW +: AW];

    // Read mux: zero when not ready or x0, else array with bypass of same-cycle writes
    always_comb begin
      data = '0;
      if (ready && (addr != '0)) begin
        data = mem_q[addr];
        for (int p = 0; p < NWR; p++) begin
          if (wr_en_i[p] && (wr_addr_w[p] == addr)) begin
            data = wr_data_w[p];
          end
        end
      end
    end

    assign rd_data_o[r*XLEN +: XLEN] = data;
  end

`ifdef REGFILE_SCOREBOARD_EN
  regfile_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .NWR   (NWR)
  ) u_scoreboard (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .ready_i      (ready),
    .alloc_en_i   (alloc_en_i),
    .alloc_addr_i (alloc_addr_i),
    .wr_en_i      (wr_en_i),
    .wr_addr_i    (wr_addr_i),
    .rd_addr_i    (rd_addr_i),
    .busy_o       (busy_o)
  );
`endif

endmodule : regfile_multiport

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport (NWR=2): directed stimulus pushes expected
// values into a queue; a negedge monitor pops and compares them.
module tb_regfile_multiport;
  import regfile_pkg::*;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned NREGS = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned NRD   = 2;
  localparam int unsigned NWR   = 2;

  localparam int K_READY = 0;
  localparam int K_RD    = 1;
  localparam int K_BUSY  = 2;

  logic                clk;
  logic                rst;
  logic                ready;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
`ifdef REGFILE_SCOREBOARD_EN
  logic                alloc_en;
  logic [AW-1:0]       alloc_addr;
  logic [NRD-1:0]      busy;
`endif

  regfile_multiport #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .NRD   (NRD),
    .NWR   (NWR)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .ready_o      (ready),
    .rd_addr_i    (rd_addr),
    .rd_data_o    (rd_data),
    .wr_en_i      (wr_en),
    .wr_addr_i    (wr_addr),
    .wr_data_i    (wr_data)
`ifdef REGFILE_SCOREBOARD_EN
    ,
    .alloc_en_i   (alloc_en),
    .alloc_addr_i (alloc_addr),
    .busy_o       (busy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    int          idx;
    logic [63:0] exp;
    int          tag;
  } exp_t;

  exp_t sbq[$];
  int   total;
  int   bad;
  int   tag;

  function automatic void want(input int kind, input int idx, input logic [63:0] v);
    exp_t e;
    e.kind = kind;
    e.idx  = idx;
    e.exp  = v;
    e.tag  = tag;
    sbq.push_back(e);
  endfunction

  function automatic string kname(input int kind);
    case (kind)
      K_READY: return "ready";
      K_RD:    return "rd_data";
      default: return "busy";
    endcase
  endfunction

  exp_t        m_e;
  logic [63:0] m_act;

  // Monitor: compare every queued expectation against the settled outputs
  always @(negedge clk) begin
    while (sbq.size() > 0) begin
      m_e = sbq.pop_front();
      case (m_e.kind)
        K_READY: m_act = 64'(ready);
        K_RD:    m_act = rd_data[m_e.idx*XLEN +: XLEN];
`ifdef REGFILE_SCOREBOARD_EN
        K_BUSY:  m_act = 64'(busy[m_e.idx]);
`endif
        default: m_act = 'x;
      endcase
      total++;
      if (m_act !== m_e.exp) begin
        bad++;
        $display("FAIL %s[%0d] tag=%0d actual=%h required=%h t=%0t",
                 kname(m_e.kind), m_e.idx, m_e.tag, m_act, m_e.exp, $time);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en   = '0;
    wr_addr = '0;
    wr_data = '0;
`ifdef REGFILE_SCOREBOARD_EN
    alloc_en   = 1'b0;
    alloc_addr = '0;
`endif
  endtask

  task automatic set_rd(input int a0, input int a1);
    rd_addr[0*AW +: AW] = AW'(a0);
    rd_addr[1*AW +: AW] = AW'(a1);
  endtask

  task automatic set_wr(input int p, input int a, input logic [63:0] d);
    wr_en[p]              = 1'b1;
    wr_addr[p*AW +: AW]   = AW'(a);
    wr_data[p*XLEN +: XLEN] = d;
  endtask

  task automatic want_rd(input logic [63:0] d0, input logic [63:0] d1);
    want(K_RD, 0, d0);
    want(K_RD, 1, d1);
  endtask

  // Clear run from the first cycle with rst=0; optional ignored write and abort
  task automatic clear_run(input int wr5_at, input int abort_at);
    for (int k = 0; k <= 31; k++) begin
      idle();
      set_rd(k, 31 - k);
      if (k == wr5_at) begin
        set_wr(0, 5, 64'hAAAA_5555_AAAA_5555);
        set_rd(5, 5);
      end
`ifdef REGFILE_SCOREBOARD_EN
      if (k < 31) begin
        alloc_en   = 1'b1;
        alloc_addr = AW'(4);
      end
      want(K_BUSY, 0, 64'd0);
      want(K_BUSY, 1, 64'd0);
`endif
      want(K_READY, 0, (k < 31) ? 64'd0 : 64'd1);
      want_rd(64'd0, 64'd0);
      if (k == abort_at) begin
        rst = 1'b1;
        step();
        return;
      end
      step();
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    tag   = 0;
    rst   = 1'b1;
    rd_addr = '0;
    idle();
    step();

    // Reset held: not ready, reads zero
    tag = 1;
    for (int i = 0; i < 3; i++) begin
      set_rd(7, 31);
      want(K_READY, 0, 64'd0);
      want_rd(64'd0, 64'd0);
`ifdef REGFILE_SCOREBOARD_EN
      want(K_BUSY, 0, 64'd0);
`endif
      step();
    end

    // First clear: ready after exactly 31 cycles
    tag = 2;
    rst = 1'b0;
    clear_run(-1, -1);

    // All addresses read zero once ready
    tag = 3;
    for (int i = 0; i < 16; i++) begin
      idle();
      set_rd(2 * i, 2 * i + 1);
      want(K_READY, 0, 64'd1);
      want_rd(64'd0, 64'd0);
      step();
    end

    // Reset mid-clear after an ignored write to x5, then full restart
    tag = 4;
    rst = 1'b1;
    idle();
    want(K_READY, 0, 64'd1);
    step();
    rst = 1'b0;
    clear_run(6, 10);
    tag = 5;
    rst = 1'b0;
    clear_run(6, -1);
    tag = 6;
    idle();
    set_rd(5, 5);
    want_rd(64'd0, 64'd0);
    step();

    // Same-cycle bypass on both ports, then array read
    tag = 7;
    idle();
    set_wr(0, 7, 64'hDEADBEEF_00000001);
    set_rd(7, 7);
    want_rd(64'hDEADBEEF_00000001, 64'hDEADBEEF_00000001);
    step();
    idle();
    want_rd(64'hDEADBEEF_00000001, 64'hDEADBEEF_00000001);
    step();

    // Two ports write x3: port 1 wins in bypass and array
    tag = 8;
    idle();
    set_wr(0, 3, 64'h11);
    set_wr(1, 3, 64'h22);
    set_rd(3, 3);
    want_rd(64'h22, 64'h22);
    step();
    idle();
    want_rd(64'h22, 64'h22);
    step();

    // Write to x0 is dropped, including bypass
    tag = 9;
    idle();
    set_wr(1, 0, 64'h55);
    set_rd(0, 3);
    want_rd(64'd0, 64'h22);
    step();
    idle();
    want_rd(64'd0, 64'h22);
    step();

    // Back-to-back writes to x10
    tag = 10;
    idle();
    set_rd(10, 10);
    set_wr(0, 10, 64'hA1);
    want_rd(64'hA1, 64'hA1);
    step();
    idle();
    set_wr(1, 10, 64'hB2);
    want_rd(64'hB2, 64'hB2);
    step();
    idle();
    want_rd(64'hB2, 64'hB2);
    step();

    // Distinct addresses on two ports, crossed reads; x31 boundary
    tag = 11;
    idle();
    set_wr(0, 11, 64'h1111);
    set_wr(1, 31, 64'hFFFF_0000_3131_3131);
    set_rd(31, 11);
    want_rd(64'hFFFF_0000_3131_3131, 64'h1111);
    step();
    idle();
    set_rd(11, 31);
    want_rd(64'h1111, 64'hFFFF_0000_3131_3131);
    step();

    // Disabled write port has no effect
    tag = 12;
    idle();
    wr_addr[0 +: AW] = AW'(7);
    wr_data[0 +: XLEN] = 64'h0BAD_0BAD_0BAD_0BAD;
    set_rd(7, 10);
    want_rd(64'hDEADBEEF_00000001, 64'hB2);
    step();
    idle();
    want_rd(64'hDEADBEEF_00000001, 64'hB2);
    step();

`ifdef REGFILE_SCOREBOARD_EN
    // Scoreboard: alloc sets next cycle, alloc beats write, write clears
    tag = 13;
    idle();
    set_rd(9, 9);
    alloc_en = 1'b1;
    alloc_addr = AW'(9);
    want(K_BUSY, 0, 64'd0);
    step();
    idle();
    alloc_en = 1'b1;
    alloc_addr = AW'(9);
    set_wr(0, 9, 64'h99);
    want(K_BUSY, 0, 64'd1);
    want(K_BUSY, 1, 64'd1);
    step();
    idle();
    set_wr(1, 9, 64'h9A);
    want(K_BUSY, 0, 64'd1);
    step();
    idle();
    want(K_BUSY, 0, 64'd0);
    want_rd(64'h9A, 64'h9A);
    step();

    // x0 can never be busy
    tag = 14;
    idle();
    alloc_en = 1'b1;
    alloc_addr = '0;
    step();
    idle();
    set_rd(0, 9);
    want(K_BUSY, 0, 64'd0);
    want(K_BUSY, 1, 64'd0);
    step();

    // Reset while x4 busy: cleared and stays clear through CLEAR
    tag = 15;
    idle();
    alloc_en = 1'b1;
    alloc_addr = AW'(4);
    step();
    idle();
    set_rd(4, 4);
    want(K_BUSY, 0, 64'd1);
    rst = 1'b1;
    step();
    want(K_BUSY, 0, 64'd0);
    want(K_READY, 0, 64'd0);
    step();
    rst = 1'b0;
    clear_run(-1, -1);
    idle();
    set_rd(4, 4);
    want(K_BUSY, 0, 64'd0);
    step();
`endif

    idle();
    step();
    step();
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL queue_drain actual=%0d required=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_regfile_multiport

// File: doc/regfile_multiport.md
# regfile_multiport

Parametrised multi-port integer register file, the successor to the 2-read/1-write register file in the decode stage. It provides NRD combinational read ports and NWR synchronous write ports, with a hardwired-zero register 0 and same-cycle write-to-read bypass. A post-reset clear sequencer zeroes the array one entry per cycle. An optional scoreboard tracks pending writes for the issue logic.

## Interface
Parameters:
- XLEN, 64, data width in bits
- NREGS, 32, number of architectural registers (power of two, ≥4); AW = $clog2(NREGS)
- NRD, 2, read port count (≥1)
- NWR, 1, write port count (≥1)

Ports:
- clk_i  in  1  single clock; all state updates on posedge
- rst_i  in  1  reset, synchronous, active-high
- ready_o  out  1  array cleared, writes accepted
- rd_addr_i  in  NRD×AW  read addresses
- rd_data_o  out  NRD×XLEN  read data
- wr_en_i  in  NWR  per-port write enable
- wr_addr_i  in  NWR×AW  write addresses
- wr_data_i  in  NWR×XLEN  write data
- (REGFILE_SCOREBOARD_EN only) alloc_en_i  in  1  mark a register as pending
- (REGFILE_SCOREBOARD_EN only) alloc_addr_i  in  AW  register to mark pending
- (REGFILE_SCOREBOARD_EN only) busy_o  out  NRD  pending flag for each read address

## Operation
- States: CLEAR, READY.
  - rst_i=1 forces state CLEAR and clear counter clr_cnt=1, from any state.
  - In CLEAR with rst_i=0: write reg[clr_cnt] ← 0 each cycle and increment clr_cnt.
  - After clearing entry NREGS-1, move to READY on the next edge.
- ready_o = (state==READY). While not READY:
  - wr_en_i is ignored.
  - All rd_data_o read 0.
  - alloc_en_i is ignored.
- Write, READY only: for each port p with wr_en_i[p] && wr_addr_i[p]!=0, reg[wr_addr_i[p]] ← wr_data_i[p] at posedge.
  - Writes to address 0 are dropped.
- Write conflict: when two or more ports write the same address in one cycle, the highest-indexed port wins.
- Read, combinational:
  - rd_addr==0 returns 0.
  - Otherwise, if any enabled write port in the same cycle targets rd_addr, return that port's data; the highest-indexed port wins.
  - Otherwise return reg[rd_addr].
- Bypass applies only when ready_o=1.

## Timing
- Reset values: ready_o=0, rd_data_o=0, busy_o=0, state CLEAR, clr_cnt=1.
- The array itself is not reset in one cycle; it is zeroed only by the sequencer.
- ready_o rises exactly NREGS-1 cycles after the first cycle with rst_i=0 (31 cycles for the default).
- Reset asserted mid-clear restarts clearing at entry 1, and ready_o stays 0.
- Read latency is 0 cycles. A write becomes visible from the array on the cycle after the write edge, and via bypass in the same cycle.
- Back-to-back writes to the same address on consecutive cycles: each cycle's reads see that cycle's write data.

## Configuration
- REGFILE_SCOREBOARD_EN defined:
  - Adds an NREGS-bit busy vector, reset to 0, with bit 0 always 0.
  - alloc_en_i sets busy[alloc_addr_i] at posedge.
  - Any enabled write clears busy[wr_addr].
  - When alloc and a write hit the same address in one cycle, alloc wins and the bit stays 1.
  - busy_o[r] = busy[rd_addr_i[r]], registered state only, with no bypass of a same-cycle write clear.
- REGFILE_SCOREBOARD_EN not defined: the scoreboard ports and logic are absent, and the block has the base behaviour only.

## Structure
- Shared package regfile_pkg holds:
  - default XLEN and NREGS constants
  - typedef reg_addr_t (logic [AW-1:0])
  - typedef xdata_t (logic [XLEN-1:0])
  - enum rf_state_e {RF_CLEAR, RF_READY}
- One sub-module, regfile_scoreboard, holds the busy vector and alloc/clear logic, instantiated under REGFILE_SCOREBOARD_EN.
- The clear sequencer and array stay in the top module.

## Test plan
- Reset for 3 cycles, then release → ready_o=0 for exactly 31 cycles, then 1. Every rd_data_o reads 0 for all 32 addresses.
- Reassert rst_i at clear cycle 10 after writing x5 during CLEAR → the write is ignored, clearing restarts, and x5 reads 0 once ready.
- READY; write port0 x7=0xDEADBEEF_00000001 while reading rd_addr=7 on both ports in the same cycle → both return 0xDEADBEEF_00000001 that cycle and the next.
- NWR=2: port0 and port1 both write x3 (0x11, 0x22) in one cycle → same-cycle read and all later reads return 0x22. A write of 0x55 to x0 → x0 reads 0.
- Scoreboard: alloc x9 → busy_o=1 next cycle. Alloc x9 again plus write x9 in one cycle → still 1. Write x9 alone → busy_o=0 next cycle.
- Reset while x4 is busy → busy_o=0, and stays 0 through CLEAR.
